// File: rtl/enemy_grid_tracker.sv
// ============================================================================
// Module   : enemy_grid_tracker
// Purpose  : Alive/dead state of the invader formation; resolves player shots
//            to grid cells, kills live enemies and reports formation extents.
//            Optional score output enabled by defining ENEMY_GRID_SCORE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_grid_tracker #(
  parameter int ROWS    = 5,
  parameter int COLS    = 11,
  parameter int PITCH_X = 44,
  parameter int PITCH_Y = 29,
  parameter int ENEMY_W = 36,
  parameter int ENEMY_H = 24
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [9:0]           form_x,
  input  logic [9:0]           form_y,
  input  logic                 shot_valid,
  input  logic [9:0]           shot_x,
  input  logic [9:0]           shot_y,
  output logic                 shot_ready,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [2:0]           resp_row,
  output logic [3:0]           resp_col,
  output logic [ROWS*COLS-1:0] alive_mask,
  output logic [5:0]           alive_count,
  output logic                 all_dead,
  output logic [3:0]           left_col,
  output logic [3:0]           right_col,
  output logic [2:0]           bottom_row
`ifdef ENEMY_GRID_SCORE_EN
  ,
  output logic [15:0]          score
`endif
);

  localparam int c_idx_w = $clog2(ROWS * COLS);
  localparam logic signed [10:0] c_span_x  = 11'(COLS * PITCH_X);
  localparam logic signed [10:0] c_span_y  = 11'(ROWS * PITCH_Y);
  localparam logic signed [10:0] c_pitch_x = 11'(PITCH_X);
  localparam logic signed [10:0] c_pitch_y = 11'(PITCH_Y);
  localparam logic signed [10:0] c_enemy_w = 11'(ENEMY_W);
  localparam logic signed [10:0] c_enemy_h = 11'(ENEMY_H);
  localparam logic [3:0]         c_last_col = 4'(COLS - 1);
  localparam logic [2:0]         c_last_row = 3'(ROWS - 1);
  localparam logic [5:0]         c_full     = 6'(ROWS * COLS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCATE = 2'd1,
    S_CHECK  = 2'd2,
    S_SCAN   = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic signed [10:0] r_rx, r_ry;
  logic               r_oob;
  logic [3:0]         r_col;
  logic [2:0]         r_row;

  logic [3:0]         r_scan_col;
  logic               r_scan_found;
  logic [3:0]         r_scan_left;
  logic [3:0]         r_scan_right;
  logic [2:0]         r_scan_bottom;

  logic signed [10:0] w_dx, w_dy;
  logic               w_oob, w_accept;
  logic               w_step_x, w_step_y, w_locate_done;
  logic [c_idx_w-1:0] w_cell_idx;
  logic               w_hit;
  logic               w_col_any;
  logic [2:0]         w_col_bottom;
  logic [3:0]         w_left_final, w_right_final;
  logic [2:0]         w_bottom_final;

  // Offsets are taken as 11-bit signed so shots left/above the formation go negative.
  assign w_dx = $signed({1'b0, shot_x}) - $signed({1'b0, form_x});
  assign w_dy = $signed({1'b0, shot_y}) - $signed({1'b0, form_y});
  assign w_oob = (w_dx < 0) || (w_dy < 0) || (w_dx >= c_span_x) || (w_dy >= c_span_y);

  assign shot_ready = (r_state == S_IDLE) && !Start;
  assign w_accept   = shot_valid && shot_ready;
  assign all_dead   = (alive_count == 6'd0);

  assign w_step_x      = (r_rx >= c_pitch_x);
  assign w_step_y      = (r_ry >= c_pitch_y);
  assign w_locate_done = r_oob || (!w_step_x && !w_step_y);

  assign w_cell_idx = c_idx_w'(r_row) * c_idx_w'(COLS) + c_idx_w'(r_col);
  assign w_hit = !r_oob && (r_rx < c_enemy_w) && (r_ry < c_enemy_h) && alive_mask[w_cell_idx];

  // Rows scanned top to bottom, so the last live one found is the column's lowest.
  always_comb begin
    w_col_any    = 1'b0;
    w_col_bottom = 3'd0;
    for (int r = 0; r < ROWS; r++) begin
      if (alive_mask[c_idx_w'(r * COLS) + c_idx_w'(r_scan_col)]) begin
        w_col_any    = 1'b1;
        w_col_bottom = 3'(r);
      end
    end
  end

  assign w_left_final   = r_scan_found ? r_scan_left : r_scan_col;
  assign w_right_final  = w_col_any ? r_scan_col : r_scan_right;
  assign w_bottom_final = (w_col_any && (w_col_bottom > r_scan_bottom)) ? w_col_bottom
                                                                          : r_scan_bottom;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_LOCATE;
      S_LOCATE: if (w_locate_done) w_next = S_CHECK;
      S_CHECK:  w_next = w_hit ? S_SCAN : S_IDLE;
      S_SCAN:   if (r_scan_col == c_last_col) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (Start) w_next = S_IDLE;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      alive_mask    <= '1;
      alive_count   <= c_full;
      left_col      <= 4'd0;
      right_col     <= c_last_col;
      bottom_row    <= c_last_row;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_row      <= 3'd0;
      resp_col      <= 4'd0;
      r_rx          <= '0;
      r_ry          <= '0;
      r_oob         <= 1'b0;
      r_col         <= 4'd0;
      r_row         <= 3'd0;
      r_scan_col    <= 4'd0;
      r_scan_found  <= 1'b0;
      r_scan_left   <= 4'd0;
      r_scan_right  <= 4'd0;
      r_scan_bottom <= 3'd0;
    end else if (Start) begin
      alive_mask    <= '1;
      alive_count   <= c_full;
      left_col      <= 4'd0;
      right_col     <= c_last_col;
      bottom_row    <= c_last_row;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_row      <= 3'd0;
      resp_col      <= 4'd0;
      r_rx          <= '0;
      r_ry          <= '0;
      r_oob         <= 1'b0;
      r_col         <= 4'd0;
      r_row         <= 3'd0;
      r_scan_col    <= 4'd0;
      r_scan_found  <= 1'b0;
      r_scan_left   <= 4'd0;
      r_scan_right  <= 4'd0;
      r_scan_bottom <= 3'd0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rx  <= w_dx;
            r_ry  <= w_dy;
            r_oob <= w_oob;
            r_col <= 4'd0;
            r_row <= 3'd0;
          end
        end
        // Repeated subtraction replaces a divider; both axes step in parallel.
        S_LOCATE: begin
          if (!w_locate_done) begin
            if (w_step_x) begin
              r_rx  <= r_rx - c_pitch_x;
              r_col <= r_col + 4'd1;
            end
            if (w_step_y) begin
              r_ry  <= r_ry - c_pitch_y;
              r_row <= r_row + 3'd1;
            end
          end
        end
        S_CHECK: begin
          resp_valid    <= 1'b1;
          resp_hit      <= w_hit;
          resp_row      <= r_oob ? 3'd0 : r_row;
          resp_col      <= r_oob ? 4'd0 : r_col;
          r_scan_col    <= 4'd0;
          r_scan_found  <= 1'b0;
          r_scan_left   <= 4'd0;
          r_scan_right  <= 4'd0;
          r_scan_bottom <= 3'd0;
          if (w_hit) begin
            alive_mask[w_cell_idx] <= 1'b0;
            alive_count            <= alive_count - 6'd1;
          end
        end
        S_SCAN: begin
          r_scan_col <= r_scan_col + 4'd1;
          if (w_col_any) begin
            r_scan_found <= 1'b1;
            if (!r_scan_found) r_scan_left <= r_scan_col;
            r_scan_right  <= r_scan_col;
            r_scan_bottom <= w_bottom_final;
          end
          // Extents are published together, and frozen once nothing is left alive.
          if ((r_scan_col == c_last_col) && !all_dead) begin
            left_col   <= w_left_final;
            right_col  <= w_right_final;
            bottom_row <= w_bottom_final;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ENEMY_GRID_SCORE_EN
  logic [15:0] w_points;
  logic [16:0] w_score_sum;

  always_comb begin
    w_points = 16'd10;
    if (r_row == 3'd0)      w_points = 16'd30;
    else if (r_row <= 3'd2) w_points = 16'd20;
  end

  assign w_score_sum = {1'b0, score} + {1'b0, w_points};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      score <= 16'd0;
    end else if (Start) begin
      score <= 16'd0;
    end else if ((r_state == S_CHECK) && w_hit) begin
      score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_enemy_grid_tracker.sv
// Directed bench for enemy_grid_tracker: formation at (100,50), hand-computed responses.
`default_nettype none

module tb_enemy_grid_tracker;

  logic        Clk = 1'b0;
  logic        Reset, Start, shot_valid;
  logic [9:0]  form_x, form_y, shot_x, shot_y;
  logic        shot_ready, resp_valid, resp_hit, all_dead;
  logic [2:0]  resp_row, bottom_row;
  logic [3:0]  resp_col, left_col, right_col;
  logic [54:0] alive_mask;
  logic [5:0]  alive_count;
`ifdef ENEMY_GRID_SCORE_EN
  logic [15:0] score;
  logic [15:0] score_at_resp;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // shot results
  int         s_lat, s_ready_lat;
  logic       s_hit, s_pulse2;
  logic [2:0] s_row;
  logic [3:0] s_col;

  enemy_grid_tracker dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .form_x(form_x), .form_y(form_y),
    .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y),
    .shot_ready(shot_ready), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_row(resp_row), .resp_col(resp_col),
    .alive_mask(alive_mask), .alive_count(alive_count), .all_dead(all_dead),
    .left_col(left_col), .right_col(right_col), .bottom_row(bottom_row)
`ifdef ENEMY_GRID_SCORE_EN
    , .score(score)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Latencies are counted in cycles from the accept cycle T (99 = timed out).
  task automatic do_shot(input logic [9:0] x, input logic [9:0] y);
    int   k;
    logic rdy;
    k = 0;
    while (!shot_ready && k < 100) begin tick(); k++; end
    shot_x = x; shot_y = y; shot_valid = 1'b1;
    tick();
    shot_valid = 1'b0;
    k = 1;
    while (!resp_valid && k < 60) begin tick(); k++; end
    s_lat = resp_valid ? k : 99;
    s_hit = resp_hit; s_row = resp_row; s_col = resp_col;
`ifdef ENEMY_GRID_SCORE_EN
    score_at_resp = score;
`endif
    rdy = shot_ready;
    tick(); k++;
    s_pulse2 = resp_valid;
    if (rdy) s_ready_lat = k - 1;
    else begin
      while (!shot_ready && k < 100) begin tick(); k++; end
      s_ready_lat = shot_ready ? k : 99;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; shot_valid = 1'b0;
    form_x = 10'd100; form_y = 10'd50; shot_x = 10'd0; shot_y = 10'd0;
    tick(); tick();
    n_total++; if (alive_mask !== {55{1'b1}}) $display("FAIL reset_mask got %h exp all ones", alive_mask); else n_pass++;
    n_total++; if (alive_count !== 6'd55) $display("FAIL reset_count got %0d exp 55", alive_count); else n_pass++;
    n_total++; if (all_dead !== 1'b0) $display("FAIL reset_all_dead got %b exp 0", all_dead); else n_pass++;
    n_total++; if ({left_col, right_col, bottom_row} !== {4'd0, 4'd10, 3'd4})
      $display("FAIL reset_extents got %0d/%0d/%0d exp 0/10/4", left_col, right_col, bottom_row); else n_pass++;
    n_total++; if ({resp_valid, resp_hit, resp_row, resp_col} !== 9'd0)
      $display("FAIL reset_resp got v%b h%b r%0d c%0d exp all 0", resp_valid, resp_hit, resp_row, resp_col); else n_pass++;
    Reset = 1'b0;
    tick();
    n_total++; if (shot_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", shot_ready); else n_pass++;
`ifdef ENEMY_GRID_SCORE_EN
    n_total++; if (score !== 16'd0) $display("FAIL reset_score got %0d exp 0", score); else n_pass++;
`endif
  endtask

  task automatic test_first_hit();
    do_shot(10'd100, 10'd50);
    n_total++; if (s_lat !== 3) $display("FAIL hit1_latency got %0d exp 3", s_lat); else n_pass++;
    n_total++; if ({s_hit, s_row, s_col} !== {1'b1, 3'd0, 4'd0})
      $display("FAIL hit1_resp got h%b r%0d c%0d exp h1 r0 c0", s_hit, s_row, s_col); else n_pass++;
    n_total++; if (s_pulse2 !== 1'b0) $display("FAIL hit1_pulse_width got %b exp 0", s_pulse2); else n_pass++;
    n_total++; if (s_ready_lat !== 14) $display("FAIL hit1_ready got %0d exp 14", s_ready_lat); else n_pass++;
    n_total++; if (alive_count !== 6'd54) $display("FAIL hit1_count got %0d exp 54", alive_count); else n_pass++;
    n_total++; if (alive_mask[0] !== 1'b0) $display("FAIL hit1_mask_bit got %b exp 0", alive_mask[0]); else n_pass++;
  endtask

  task automatic test_long_locate();
    do_shot(10'd575, 10'd189);
    n_total++; if (s_lat !== 13) $display("FAIL long_latency got %0d exp 13", s_lat); else n_pass++;
    n_total++; if ({s_hit, s_row, s_col} !== {1'b1, 3'd4, 4'd10})
      $display("FAIL long_resp got h%b r%0d c%0d exp h1 r4 c10", s_hit, s_row, s_col); else n_pass++;
    n_total++; if (s_ready_lat !== 24) $display("FAIL long_ready got %0d exp 24", s_ready_lat); else n_pass++;
    n_total++; if ({alive_count, bottom_row, right_col} !== {6'd53, 3'd4, 4'd10})
      $display("FAIL long_state got cnt%0d bot%0d right%0d exp 53/4/10", alive_count, bottom_row, right_col); else n_pass++;
  endtask

  task automatic test_miss();
    logic [54:0] exp_mask;
    exp_mask = '1; exp_mask[0] = 1'b0; exp_mask[54] = 1'b0;
    do_shot(10'd140, 10'd50);
    n_total++; if ({s_lat, s_hit, s_row, s_col} !== {32'd3, 1'b0, 3'd0, 4'd0})
      $display("FAIL gap_resp got lat%0d h%b r%0d c%0d exp lat3 h0 r0 c0", s_lat, s_hit, s_row, s_col); else n_pass++;
    n_total++; if (s_ready_lat !== 3) $display("FAIL gap_ready got %0d exp 3", s_ready_lat); else n_pass++;
    do_shot(10'd99, 10'd50);
    n_total++; if ({s_lat, s_hit, s_row, s_col} !== {32'd3, 1'b0, 3'd0, 4'd0})
      $display("FAIL oob_resp got lat%0d h%b r%0d c%0d exp lat3 h0 r0 c0", s_lat, s_hit, s_row, s_col); else n_pass++;
    // dx=49 -> col1 rx5, dy=54 -> row1 ry25: vertical gap
    do_shot(10'd149, 10'd104);
    n_total++; if ({s_lat, s_hit, s_row, s_col} !== {32'd4, 1'b0, 3'd1, 4'd1})
      $display("FAIL vgap_resp got lat%0d h%b r%0d c%0d exp lat4 h0 r1 c1", s_lat, s_hit, s_row, s_col); else n_pass++;
    n_total++; if (alive_mask !== exp_mask) $display("FAIL miss_mask got %h exp %h", alive_mask, exp_mask); else n_pass++;
    n_total++; if (alive_count !== 6'd53) $display("FAIL miss_count got %0d exp 53", alive_count); else n_pass++;
  endtask

  task automatic test_edges();
    int hits;
    hits = 0;
    for (int r = 1; r < 5; r++) begin
      do_shot(10'd102, 10'(52 + 29 * r));
      n_total++; if ({s_hit, s_lat} !== {1'b1, 32'(r + 3)})
        $display("FAIL col0_kill r%0d got h%b lat%0d exp h1 lat%0d", r, s_hit, s_lat, r + 3); else n_pass++;
    end
    n_total++; if ({left_col, right_col} !== {4'd1, 4'd10})
      $display("FAIL col0_extents got %0d/%0d exp 1/10", left_col, right_col); else n_pass++;
    for (int r = 0; r < 4; r++) begin
      do_shot(10'd542, 10'(52 + 29 * r));
      if (s_hit === 1'b1 && s_col === 4'd10) hits++;
    end
    n_total++; if (hits !== 4) $display("FAIL col10_kills got %0d exp 4", hits); else n_pass++;
    n_total++; if ({left_col, right_col, bottom_row} !== {4'd1, 4'd9, 3'd4})
      $display("FAIL edges got %0d/%0d/%0d exp 1/9/4", left_col, right_col, bottom_row); else n_pass++;
    n_total++; if (alive_count !== 6'd45) $display("FAIL edges_count got %0d exp 45", alive_count); else n_pass++;
    do_shot(10'd102, 10'd52);
    n_total++; if ({s_hit, s_row, s_col, s_ready_lat} !== {1'b0, 3'd0, 4'd0, 32'd3})
      $display("FAIL dead_cell got h%b r%0d c%0d rdy%0d exp h0 r0 c0 rdy3", s_hit, s_row, s_col, s_ready_lat); else n_pass++;
  endtask

  task automatic test_start_abort();
    int seen;
    shot_x = 10'd575; shot_y = 10'd189; shot_valid = 1'b1;
    tick();
    shot_valid = 1'b0;
    tick(); tick();
    Start = 1'b1;
    #1;
    n_total++; if (shot_ready !== 1'b0) $display("FAIL abort_ready_during got %b exp 0", shot_ready); else n_pass++;
    tick();
    Start = 1'b0;
    #1;
    n_total++; if (shot_ready !== 1'b1) $display("FAIL abort_ready_after got %b exp 1", shot_ready); else n_pass++;
    n_total++; if ({alive_mask, alive_count} !== {{55{1'b1}}, 6'd55})
      $display("FAIL abort_reload got mask %h cnt %0d exp all ones/55", alive_mask, alive_count); else n_pass++;
    n_total++; if ({left_col, right_col, bottom_row} !== {4'd0, 4'd10, 3'd4})
      $display("FAIL abort_extents got %0d/%0d/%0d exp 0/10/4", left_col, right_col, bottom_row); else n_pass++;
    // Start together with shot_valid while idle: shot must be dropped
    shot_x = 10'd100; shot_y = 10'd50; shot_valid = 1'b1; Start = 1'b1;
    tick();
    shot_valid = 1'b0; Start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) seen++;
      tick();
    end
    n_total++; if (seen !== 0) $display("FAIL abort_no_resp got %0d pulses exp 0", seen); else n_pass++;
    n_total++; if (alive_count !== 6'd55) $display("FAIL start_drop_count got %0d exp 55", alive_count); else n_pass++;
  endtask

  task automatic test_wipe_out();
    int hits;
    Start = 1'b1; tick(); Start = 1'b0;
    do_shot(10'd101, 10'd51);
`ifdef ENEMY_GRID_SCORE_EN
    n_total++; if (score_at_resp !== 16'd30) $display("FAIL score_r0 got %0d exp 30", score_at_resp); else n_pass++;
`endif
    do_shot(10'd101, 10'd109);
`ifdef ENEMY_GRID_SCORE_EN
    n_total++; if (score_at_resp !== 16'd50) $display("FAIL score_r2 got %0d exp 50", score_at_resp); else n_pass++;
`endif
    do_shot(10'd101, 10'd167);
    n_total++; if ({s_hit, s_row, s_lat} !== {1'b1, 3'd4, 32'd7})
      $display("FAIL r4c0_hit got h%b r%0d lat%0d exp h1 r4 lat7", s_hit, s_row, s_lat); else n_pass++;
`ifdef ENEMY_GRID_SCORE_EN
    n_total++; if (score_at_resp !== 16'd60) $display("FAIL score_r4 got %0d exp 60", score_at_resp); else n_pass++;
`endif
    hits = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 11; c++) begin
        if (!(c == 0 && (r % 2) == 0)) begin
          do_shot(10'(101 + 44 * c), 10'(51 + 29 * r));
          if (s_hit === 1'b1) hits++;
        end
      end
    end
    n_total++; if (hits !== 52) $display("FAIL wipe_hits got %0d exp 52", hits); else n_pass++;
    n_total++; if ({all_dead, alive_count, alive_mask} !== {1'b1, 6'd0, 55'd0})
      $display("FAIL wipe_state got dead%b cnt%0d mask %h exp 1/0/0", all_dead, alive_count, alive_mask); else n_pass++;
    n_total++; if ({left_col, right_col, bottom_row} !== {4'd10, 4'd10, 3'd4})
      $display("FAIL wipe_hold got %0d/%0d/%0d exp 10/10/4", left_col, right_col, bottom_row); else n_pass++;
`ifdef ENEMY_GRID_SCORE_EN
    n_total++; if (score !== 16'd990) $display("FAIL score_total got %0d exp 990", score); else n_pass++;
`endif
    do_shot(10'd101, 10'd51);
    n_total++; if ({s_lat, s_hit, s_row, s_col, alive_count} !== {32'd3, 1'b0, 3'd0, 4'd0, 6'd0})
      $display("FAIL dead_shot got lat%0d h%b r%0d c%0d cnt%0d exp lat3 h0 r0 c0 cnt0",
               s_lat, s_hit, s_row, s_col, alive_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_hit();
    test_long_locate();
    test_miss();
    test_edges();
    test_start_abort();
    test_wipe_out();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
